// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 word mux toward one valid/ready sink.
// A grant holds for up to MAX_BURST accepted beats, then priority rotates past the winner.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       out_valid,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  state_t           state_r, state_nx_s;
  logic [1:0]       sel_r, sel_nx_s;
  logic [3:0]       gnt_r, gnt_nx_s;
  logic [1:0]       ptr_r, ptr_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [3:0]       ack_s;
  logic             valid_s;
  logic [1:0]       win_s;

  // First set request bit at or after the priority pointer, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] w;
    logic [1:0] idx;
    w = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) begin
        w = idx;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  assign win_s     = rr_pick(req, ptr_r);
  assign valid_s   = (state_r == BUSY) && req[sel_r];
  assign busy      = (state_r == BUSY);
  assign sel       = sel_r;
  assign gnt       = gnt_r;
  assign out_valid = valid_s;
  assign ack       = ack_s;

  // Next-state, grant bookkeeping and beat acknowledge.
  always_comb begin
    state_nx_s = state_r;
    sel_nx_s   = sel_r;
    gnt_nx_s   = gnt_r;
    ptr_nx_s   = ptr_r;
    cnt_nx_s   = cnt_r;
    ack_s      = 4'b0000;
    case (state_r)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_nx_s   = win_s;
          gnt_nx_s   = onehot4(win_s);
          cnt_nx_s   = '0;
          state_nx_s = BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        // A withdrawn request or the final beat both release; sel keeps its value.
        if (!req[sel_r]) begin
          state_nx_s = IDLE;
          gnt_nx_s   = 4'b0000;
          ptr_nx_s   = sel_r + 2'd1;
        end else if (out_ready) begin
          ack_s = onehot4(sel_r);
          if (cnt_r == LAST_BEAT) begin
            state_nx_s = IDLE;
            gnt_nx_s   = 4'b0000;
            ptr_nx_s   = sel_r + 2'd1;
          end else begin
            cnt_nx_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_nx_s = BUSY;
        end
      end
      default: begin
        state_nx_s = IDLE;
        gnt_nx_s   = 4'b0000;
      end
    endcase
  end

  // State and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sel_r   <= 2'd0;
      gnt_r   <= 4'b0000;
      ptr_r   <= 2'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      sel_r   <= sel_nx_s;
      gnt_r   <= gnt_nx_s;
      ptr_r   <= ptr_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

endmodule
